// File: rtl/gpio_cmd_pkg.sv
// gpio_cmd_pkg
// Shared definitions for the GPIO command sequencer: the sequencer state
// encoding, the field positions inside the PS control word, the bit
// positions inside the low nibble of the status word, and a small helper
// that assembles that nibble from named flags.
package gpio_cmd_pkg;

   // Sequencer states: waiting for a new seq, offering the command to the
   // datapath, and waiting for the datapath's completion pulse.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } cmdState_t;

   // Control word layout: [31:24] seq, [23:16] opcode, [15:0] arg.
   localparam int SEQ_LSB = 24;
   localparam int SEQ_MSB = 31;
   localparam int OP_LSB  = 16;
   localparam int OP_MSB  = 23;
   localparam int ARG_LSB = 0;
   localparam int ARG_MSB = 15;

   // Status word low nibble bit positions.
   localparam int STAT_DONE = 0;
   localparam int STAT_BUSY = 1;
   localparam int STAT_ERR  = 2;
   localparam int STAT_TO   = 3;

   // Builds the status flag nibble from individual flags so callers never
   // depend on the raw bit ordering.
   function automatic logic [3:0] makeStatusBits(input logic done,
                                                 input logic busyFlag,
                                                 input logic err,
                                                 input logic timeout);
      logic [3:0] bits;
      bits            = 4'b0000;
      bits[STAT_DONE] = done;
      bits[STAT_BUSY] = busyFlag;
      bits[STAT_ERR]  = err;
      bits[STAT_TO]   = timeout;
      return bits;
   endfunction

endpackage

// File: rtl/gpio_cmd_timer.sv
// gpio_cmd_timer
// Clear/enable counter with a terminal-count flag, used as the ISSUE+WAIT
// watchdog of the command sequencer. The whole module only exists when
// GPIO_CMD_TIMEOUT_EN is defined, so the default build carries no orphan
// module alongside the sequencer.
//
// Parameters:
//   WIDTH    - counter width
//   TERMINAL - count value at which atTerminal is raised
// Ports:
//   clock      in  1 - clock
//   reset      in  1 - asynchronous active-high reset
//   clear      in  1 - synchronous clear, has priority over enable
//   enable     in  1 - count up by one this cycle
//   atTerminal out 1 - count currently equals TERMINAL
`ifdef GPIO_CMD_TIMEOUT_EN
module gpio_cmd_timer #(
   parameter int WIDTH    = 24,
   parameter int TERMINAL = 999_999
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic atTerminal
);

   logic [WIDTH-1:0] count;

   // Counter register: a clear restarts the budget for a fresh command,
   // otherwise the count advances on every enabled cycle and simply holds
   // while the sequencer sits idle.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable) begin
         count <= count + WIDTH'(1);
      end
   end

   assign atTerminal = (count == WIDTH'(TERMINAL));

endmodule
`endif

// File: rtl/gpio_cmd_handshake.sv
// gpio_cmd_handshake
// Command sequencer downstream of the GPIO register array. It watches the
// PS control word for a new, stable, nonzero sequence number, offers the
// latched opcode/argument to a PL datapath over a valid/ready handshake,
// waits for the datapath's completion pulse and reports the outcome in a
// status word that software polls.
//
// Optional feature macro: GPIO_CMD_TIMEOUT_EN builds a watchdog that aborts
// a command after TIMEOUT_CYCLES cycles in ISSUE+WAIT and flags status[3].
// Without it the sequencer waits indefinitely and status[3] is always 0.
//
// Parameters:
//   TIMEOUT_CYCLES - ISSUE+WAIT cycle budget (2..2^24-1), timeout build only
//   TO_WIDTH       - watchdog counter width, timeout build only
// Ports:
//   aclk        in  1  - clock
//   areset      in  1  - asynchronous active-high reset
//   ctrl_word   in  32 - {seq, opcode, arg} from the register array
//   status_word out 32 - {seq echo, opcode echo, 12'h0, to, err, busy, done}
//   cmd_valid   out 1  - command offered to the datapath
//   cmd_ready   in  1  - datapath accepts the command
//   cmd_op      out 8  - latched opcode
//   cmd_arg     out 16 - latched argument
//   resp_done   in  1  - single-cycle completion pulse
//   resp_err    in  1  - error flag, qualified by resp_done
//   busy        out 1  - a command is in ISSUE or WAIT
module gpio_cmd_handshake
   import gpio_cmd_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1_000_000,
   parameter int TO_WIDTH       = 24
) (
   input  logic        aclk,
   input  logic        areset,
   input  logic [31:0] ctrl_word,
   output logic [31:0] status_word,
   output logic        cmd_valid,
   input  logic        cmd_ready,
   output logic [7:0]  cmd_op,
   output logic [15:0] cmd_arg,
   input  logic        resp_done,
   input  logic        resp_err,
   output logic        busy
);

   cmdState_t   state;
   cmdState_t   nextState;
   logic [31:0] ctrlQ;
   logic [7:0]  lastSeq;
   logic [7:0]  statusSeq;
   logic [7:0]  statusOp;
   logic [3:0]  statusBits;
   logic [7:0]  newSeq;
   logic [7:0]  newOp;
   logic [15:0] newArg;
   logic        accept;
   logic        respSeen;
   logic        timedOut;

   assign newSeq = ctrl_word[SEQ_MSB:SEQ_LSB];
   assign newOp  = ctrl_word[OP_MSB:OP_LSB];
   assign newArg = ctrl_word[ARG_MSB:ARG_LSB];

   // Completion only counts while waiting; a pulse during ISSUE, including
   // the handshake cycle itself, is deliberately dropped.
   assign respSeen = (state == WAIT) && resp_done;

`ifdef GPIO_CMD_TIMEOUT_EN
   logic timerTerminal;

   // Watchdog restarts on every accepted command and only runs while a
   // command is outstanding. A completion arriving in the terminal cycle
   // takes precedence so a finished command is never reported as aborted.
   gpio_cmd_timer #(
      .WIDTH    (TO_WIDTH),
      .TERMINAL (TIMEOUT_CYCLES - 1)
   ) timerInst (
      .clock      (aclk),
      .reset      (areset),
      .clear      (accept),
      .enable     (state != IDLE),
      .atTerminal (timerTerminal)
   );

   assign timedOut = (state != IDLE) && timerTerminal && !respSeen;
`else
   assign timedOut = 1'b0;
`endif

   // State register. Reset returns to IDLE immediately, which also drops
   // cmd_valid and busy without waiting for a clock edge.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Next-state logic. A command is accepted only from IDLE when the control
   // word has been stable for a full cycle (so a half-written word from the
   // PS is never sampled), its seq is nonzero, and the seq differs from the
   // last one issued. A seq written while busy therefore waits here until the
   // sequencer returns to IDLE, acting as a one-deep pending slot.
   always_comb begin
      nextState = state;
      accept    = 1'b0;
      case (state)
         IDLE: begin
            if ((ctrl_word == ctrlQ) && (newSeq != 8'h00) && (newSeq != lastSeq)) begin
               accept    = 1'b1;
               nextState = ISSUE;
            end
         end
         ISSUE: begin
            if (timedOut) begin
               nextState = IDLE;
            end else if (cmd_ready) begin
               nextState = WAIT;
            end
         end
         WAIT: begin
            if (respSeen || timedOut) begin
               nextState = IDLE;
            end
         end
         default: nextState = IDLE;
      endcase
   end

   // Datapath registers: the one-cycle-old control sample used for the
   // stability check, the latched command operands, the last issued seq and
   // the status fields. Done/error/timeout flags are only rewritten by the
   // next accept, so software can read the result at leisure.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         ctrlQ      <= '0;
         lastSeq    <= '0;
         cmd_op     <= '0;
         cmd_arg    <= '0;
         statusSeq  <= '0;
         statusOp   <= '0;
         statusBits <= '0;
      end else begin
         ctrlQ <= ctrl_word;
         if (accept) begin
            lastSeq    <= newSeq;
            cmd_op     <= newOp;
            cmd_arg    <= newArg;
            statusSeq  <= newSeq;
            statusOp   <= newOp;
            statusBits <= makeStatusBits(1'b0, 1'b1, 1'b0, 1'b0);
         end else if (respSeen) begin
            statusBits <= makeStatusBits(1'b1, 1'b0, resp_err, 1'b0);
         end else if (timedOut) begin
            statusBits <= makeStatusBits(1'b1, 1'b0, 1'b1, 1'b1);
         end
      end
   end

   // Handshake outputs follow the state directly so they clear as soon as
   // reset asserts.
   assign cmd_valid   = (state == ISSUE);
   assign busy        = (state != IDLE);
   assign status_word = {statusSeq, statusOp, 12'h000, statusBits};

endmodule

// File: tb/tb_gpio_cmd_handshake.sv
// tb_gpio_cmd_handshake
// Scenario bench for gpio_cmd_handshake. Each test task drives its own
// stimulus and compares outputs against expectations derived from the
// command rules: a new nonzero seq is taken two edges after it is written,
// the status word is {seq, opcode, 12'h0, flags} and the last issued seq is
// remembered by the model.
module tb_gpio_cmd_handshake;

   localparam int TIMEOUT_CYCLES = 16;
   localparam int TO_WIDTH       = 24;

   logic        aclk;
   logic        areset;
   logic [31:0] ctrl_word;
   logic [31:0] status_word;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [7:0]  cmd_op;
   logic [15:0] cmd_arg;
   logic        resp_done;
   logic        resp_err;
   logic        busy;

   int errors = 0;
   int checks = 0;

   logic [7:0]  modelLastSeq;
   logic [31:0] modelStatus;

   gpio_cmd_handshake #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .TO_WIDTH       (TO_WIDTH)
   ) dut (
      .aclk        (aclk),
      .areset      (areset),
      .ctrl_word   (ctrl_word),
      .status_word (status_word),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_op      (cmd_op),
      .cmd_arg     (cmd_arg),
      .resp_done   (resp_done),
      .resp_err    (resp_err),
      .busy        (busy)
   );

   // Free-running 100 MHz clock.
   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   // Advances n clock edges and parks 1 ns after the last one, where outputs
   // are sampled and new inputs are driven.
   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge aclk);
         #1;
      end
   endtask

   task automatic applyStimulus(input logic [31:0] word, input logic ready,
                                input logic done, input logic err);
      ctrl_word = word;
      cmd_ready = ready;
      resp_done = done;
      resp_err  = err;
   endtask

   // Expected status while a command is outstanding.
   function automatic logic [31:0] busyStatus(input logic [31:0] word);
      logic [7:0] seq;
      logic [7:0] op;
      seq = word[31:24];
      op  = word[23:16];
      return {seq, op, 16'h0002};
   endfunction

   // Expected status after the datapath reports completion.
   function automatic logic [31:0] doneStatus(input logic [31:0] word, input logic err);
      logic [7:0] seq;
      logic [7:0] op;
      seq = word[31:24];
      op  = word[23:16];
      return {seq, op, 16'h0001 + (err ? 16'h0004 : 16'h0000)};
   endfunction

   task automatic test_reset();
      applyStimulus(32'h0, 1'b0, 1'b0, 1'b0);
      areset = 1'b1;
      step(2);
      checks++;
      if (status_word !== 32'h0 || cmd_valid !== 1'b0 || busy !== 1'b0 ||
          cmd_op !== 8'h0 || cmd_arg !== 16'h0) begin
         errors++;
         $display("[TB] FAIL reset_outputs status=%h valid=%b busy=%b op=%h arg=%h expected all zero",
                  status_word, cmd_valid, busy, cmd_op, cmd_arg);
      end
      areset = 1'b0;
      modelLastSeq = 8'h00;
      modelStatus  = 32'h0;
      step(3);
      checks++;
      if (cmd_valid !== 1'b0 || status_word !== modelStatus) begin
         errors++;
         $display("[TB] FAIL reset_idle valid=%b status=%h expected valid=0 status=%h",
                  cmd_valid, status_word, modelStatus);
      end
   endtask

   task automatic test_basic();
      logic [31:0] word;
      word = 32'h01_05_1234;
      applyStimulus(word, 1'b1, 1'b0, 1'b0);
      step();
      checks++;
      if (cmd_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL basic_stability valid=%b expected 0", cmd_valid);
      end
      step();
      modelLastSeq = 8'h01;
      modelStatus  = busyStatus(word);
      checks++;
      if (cmd_valid !== 1'b1 || cmd_op !== 8'h05 || cmd_arg !== 16'h1234 ||
          status_word !== 32'h01_05_0002 || busy !== 1'b1) begin
         errors++;
         $display("[TB] FAIL basic_accept valid=%b op=%h arg=%h status=%h busy=%b expected 1 05 1234 01050002 1",
                  cmd_valid, cmd_op, cmd_arg, status_word, busy);
      end
      step();
      cmd_ready = 1'b0;
      checks++;
      if (cmd_valid !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("[TB] FAIL basic_single_valid valid=%b busy=%b expected valid=0 busy=1", cmd_valid, busy);
      end
      step();
      resp_done = 1'b1;
      step();
      resp_done = 1'b0;
      modelStatus = doneStatus(word, 1'b0);
      checks++;
      if (status_word !== 32'h01_05_0001 || busy !== 1'b0 || cmd_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL basic_done status=%h busy=%b valid=%b expected 01050001 0 0",
                  status_word, busy, cmd_valid);
      end
   endtask

   task automatic test_ready_stall();
      logic [31:0] word;
      int          unstable;
      word = {8'h02, 8'($urandom), 16'($urandom)};
      applyStimulus(word, 1'b0, 1'b0, 1'b0);
      step(2);
      modelLastSeq = 8'h02;
      modelStatus  = busyStatus(word);
      unstable = 0;
      for (int i = 0; i < 10; i++) begin
         resp_done = (i == 4);
         step();
         if (cmd_valid !== 1'b1 || cmd_op !== word[23:16] || cmd_arg !== word[15:0] ||
             status_word !== modelStatus)
            unstable++;
      end
      checks++;
      if (unstable != 0) begin
         errors++;
         $display("[TB] FAIL stall_hold unstable_cycles=%0d expected 0 (op=%h arg=%h status=%h)",
                  unstable, cmd_op, cmd_arg, status_word);
      end
      cmd_ready = 1'b1;
      resp_done = 1'b1;
      step();
      applyStimulus(word, 1'b0, 1'b0, 1'b0);
      checks++;
      if (cmd_valid !== 1'b0 || busy !== 1'b1 || status_word !== modelStatus) begin
         errors++;
         $display("[TB] FAIL stall_handshake valid=%b busy=%b status=%h expected 0 1 %h",
                  cmd_valid, busy, status_word, modelStatus);
      end
      resp_done = 1'b1;
      resp_err  = 1'b1;
      step();
      resp_done = 1'b0;
      resp_err  = 1'b0;
      modelStatus = doneStatus(word, 1'b1);
      checks++;
      if (status_word !== modelStatus || busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL stall_error_done status=%h busy=%b expected %h 0",
                  status_word, busy, modelStatus);
      end
   endtask

   task automatic test_pending();
      logic [31:0] word3;
      logic [31:0] word4;
      int          extra;
      word3 = {8'h03, 8'($urandom), 16'($urandom)};
      word4 = {8'h04, 8'($urandom), 16'($urandom)};
      applyStimulus(word3, 1'b0, 1'b0, 1'b0);
      step(2);
      modelLastSeq = 8'h03;
      modelStatus  = busyStatus(word3);
      cmd_ready = 1'b1;
      step();
      cmd_ready = 1'b0;
      ctrl_word = word4;
      extra = 0;
      for (int i = 0; i < 6; i++) begin
         step();
         if (cmd_valid !== 1'b0 || busy !== 1'b1 || status_word !== modelStatus)
            extra++;
      end
      checks++;
      if (extra != 0) begin
         errors++;
         $display("[TB] FAIL pending_no_reissue bad_cycles=%0d expected 0 status=%h", extra, status_word);
      end
      resp_done = 1'b1;
      step();
      resp_done = 1'b0;
      modelStatus = doneStatus(word3, 1'b0);
      checks++;
      if (status_word !== modelStatus || cmd_valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL pending_first_done status=%h valid=%b busy=%b expected %h 0 0",
                  status_word, cmd_valid, busy, modelStatus);
      end
      step();
      modelLastSeq = 8'h04;
      modelStatus  = busyStatus(word4);
      checks++;
      if (cmd_valid !== 1'b1 || status_word !== modelStatus ||
          cmd_op !== word4[23:16] || cmd_arg !== word4[15:0]) begin
         errors++;
         $display("[TB] FAIL pending_back_to_back valid=%b status=%h op=%h arg=%h expected 1 %h %h %h",
                  cmd_valid, status_word, cmd_op, cmd_arg, modelStatus, word4[23:16], word4[15:0]);
      end
      cmd_ready = 1'b1;
      step();
      cmd_ready = 1'b0;
      resp_done = 1'b1;
      step();
      resp_done = 1'b0;
      modelStatus = doneStatus(word4, 1'b0);
   endtask

   task automatic test_ignore();
      logic [31:0] words [2];
      int          bad;
      words[0] = {8'h04, 8'($urandom), 16'($urandom)};
      words[1] = {8'h00, 8'($urandom), 16'($urandom)};
      for (int w = 0; w < 2; w++) begin
         applyStimulus(words[w], 1'b1, 1'b0, 1'b0);
         bad = 0;
         for (int i = 0; i < 6; i++) begin
            step();
            if (cmd_valid !== 1'b0 || busy !== 1'b0 || status_word !== modelStatus)
               bad++;
         end
         checks++;
         if (bad != 0) begin
            errors++;
            $display("[TB] FAIL ignore_word_%0d word=%h bad_cycles=%0d status=%h expected %h",
                     w, words[w], bad, status_word, modelStatus);
         end
      end
      cmd_ready = 1'b0;
   endtask

   task automatic test_timeout();
      logic [31:0] word;
      word = {8'h05, 8'($urandom), 16'($urandom)};
      applyStimulus(word, 1'b0, 1'b0, 1'b0);
      step(2);
      modelLastSeq = 8'h05;
      modelStatus  = busyStatus(word);
`ifdef GPIO_CMD_TIMEOUT_EN
      begin
         int highCycles;
         highCycles = 0;
         for (int i = 0; i < 64 && cmd_valid === 1'b1; i++) begin
            highCycles++;
            step();
         end
         checks++;
         if (highCycles != TIMEOUT_CYCLES) begin
            errors++;
            $display("[TB] FAIL timeout_length valid_cycles=%0d expected %0d", highCycles, TIMEOUT_CYCLES);
         end
         modelStatus = {word[31:16], 16'h000D};
         checks++;
         if (status_word !== modelStatus || busy !== 1'b0 || cmd_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL timeout_status status=%h busy=%b valid=%b expected %h 0 0",
                     status_word, busy, cmd_valid, modelStatus);
         end
         step(3);
         checks++;
         if (cmd_valid !== 1'b0 || status_word !== modelStatus) begin
            errors++;
            $display("[TB] FAIL timeout_no_reissue valid=%b status=%h expected 0 %h",
                     cmd_valid, status_word, modelStatus);
         end
      end
`else
      step(40);
      checks++;
      if (cmd_valid !== 1'b1 || busy !== 1'b1 || status_word !== modelStatus) begin
         errors++;
         $display("[TB] FAIL no_timeout_wait valid=%b busy=%b status=%h expected 1 1 %h",
                  cmd_valid, busy, status_word, modelStatus);
      end
      cmd_ready = 1'b1;
      step();
      cmd_ready = 1'b0;
      resp_done = 1'b1;
      step();
      resp_done = 1'b0;
      modelStatus = doneStatus(word, 1'b0);
      checks++;
      if (status_word !== modelStatus) begin
         errors++;
         $display("[TB] FAIL no_timeout_done status=%h expected %h", status_word, modelStatus);
      end
`endif
   endtask

   task automatic test_reset_mid_wait();
      logic [31:0] word;
      word = {8'h07, 8'($urandom), 16'($urandom)};
      applyStimulus(word, 1'b0, 1'b0, 1'b0);
      step(2);
      cmd_ready = 1'b1;
      step();
      cmd_ready = 1'b0;
      step();
      #3;
      areset = 1'b1;
      #1;
      checks++;
      if (status_word !== 32'h0 || cmd_valid !== 1'b0 || busy !== 1'b0 ||
          cmd_op !== 8'h0 || cmd_arg !== 16'h0) begin
         errors++;
         $display("[TB] FAIL async_reset status=%h valid=%b busy=%b op=%h arg=%h expected all zero",
                  status_word, cmd_valid, busy, cmd_op, cmd_arg);
      end
      step(2);
      areset = 1'b0;
      modelLastSeq = 8'h00;
      modelStatus  = 32'h0;
      step();
      checks++;
      if (cmd_valid !== 1'b0 || status_word !== modelStatus) begin
         errors++;
         $display("[TB] FAIL reset_reissue_early valid=%b status=%h expected 0 %h",
                  cmd_valid, status_word, modelStatus);
      end
      step();
      modelLastSeq = 8'h07;
      modelStatus  = busyStatus(word);
      checks++;
      if (cmd_valid !== 1'b1 || status_word !== modelStatus || cmd_arg !== word[15:0]) begin
         errors++;
         $display("[TB] FAIL reset_reissue valid=%b status=%h arg=%h expected 1 %h %h",
                  cmd_valid, status_word, cmd_arg, modelStatus, word[15:0]);
      end
      cmd_ready = 1'b1;
      step();
      cmd_ready = 1'b0;
      resp_done = 1'b1;
      step();
      resp_done = 1'b0;
      modelStatus = doneStatus(word, 1'b0);
      checks++;
      if (status_word !== modelStatus) begin
         errors++;
         $display("[TB] FAIL reset_reissue_done status=%h expected %h", status_word, modelStatus);
      end
   endtask

   task automatic test_random();
      logic [31:0] word;
      logic [7:0]  seq;
      logic        err;
      int          readyDelay;
      int          doneDelay;
      for (int n = 0; n < 24; n++) begin
         do seq = 8'($urandom_range(1, 255)); while (seq == modelLastSeq);
         word       = {seq, 8'($urandom), 16'($urandom)};
         readyDelay = int'($urandom_range(0, 4));
         doneDelay  = int'($urandom_range(0, 3));
         err        = 1'($urandom_range(0, 1));
         applyStimulus(word, 1'b0, 1'b0, 1'b0);
         step(2);
         modelLastSeq = seq;
         modelStatus  = busyStatus(word);
         checks++;
         if (cmd_valid !== 1'b1 || cmd_op !== word[23:16] || cmd_arg !== word[15:0] ||
             status_word !== modelStatus) begin
            errors++;
            $display("[TB] FAIL random_accept_%0d valid=%b op=%h arg=%h status=%h expected 1 %h %h %h",
                     n, cmd_valid, cmd_op, cmd_arg, status_word, word[23:16], word[15:0], modelStatus);
         end
         step(readyDelay);
         cmd_ready = 1'b1;
         step();
         cmd_ready = 1'b0;
         step(doneDelay);
         resp_done = 1'b1;
         resp_err  = err;
         step();
         resp_done = 1'b0;
         resp_err  = 1'b0;
         modelStatus = doneStatus(word, err);
         checks++;
         if (status_word !== modelStatus || busy !== 1'b0 || cmd_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL random_done_%0d status=%h busy=%b valid=%b expected %h 0 0",
                     n, status_word, busy, cmd_valid, modelStatus);
         end
      end
   endtask

   // Guards against a stuck simulation independently of the scenarios.
   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      areset    = 1'b1;
      ctrl_word = 32'h0;
      cmd_ready = 1'b0;
      resp_done = 1'b0;
      resp_err  = 1'b0;
      test_reset();
      test_basic();
      test_ready_stall();
      test_pending();
      test_ignore();
      test_timeout();
      test_reset_mid_wait();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/gpio_cmd_handshake.md
# gpio_cmd_handshake

Command sequencer that sits directly downstream of the GPIO register array. It watches one PS-written control register (an `outNN` port of the array) for a new sequence number, then issues a valid/ready command to a PL datapath and waits for its completion. It writes a status word back through one `inNN` port so software can poll the result.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 1_000_000 — ISSUE+WAIT cycle budget before abort; legal range 2..2^24-1.
- `TO_WIDTH`, 24 — width of the timeout counter.

Ports:
- `aclk`  in  1  — single clock; all logic is synchronous to it.
- `areset`  in  1  — asynchronous, active-high reset.
- `ctrl_word`  in  32  — connects to the array's control `outNN`. Fields: [31:24] seq, [23:16] opcode, [15:0] arg.
- `status_word`  out  32  — connects to the array's status `inNN`. Fields: [31:24] seq echo, [23:16] opcode echo, [15:4] zero, [3] timeout, [2] error, [1] busy, [0] done.
- `cmd_valid`  out  1  — command offered to the datapath.
- `cmd_ready`  in  1  — datapath accepts the command.
- `cmd_op`  out  8  — latched opcode.
- `cmd_arg`  out  16  — latched argument.
- `resp_done`  in  1  — single-cycle completion pulse from the datapath.
- `resp_err`  in  1  — error flag, qualified by `resp_done`.
- `busy`  out  1  — high in ISSUE or WAIT.

## Operation
- All outputs reset to 0. State resets to IDLE; `last_seq` resets to 0; `ctrl_q` (the previous-cycle sample of `ctrl_word`) resets to 0.
- Accept condition: state is IDLE, `ctrl_word == ctrl_q`, `ctrl_word[31:24] != 0`, and `ctrl_word[31:24] != last_seq`.
  - The stability check guards against sampling a word mid-update.
  - On accept: latch opcode to `cmd_op` and arg to `cmd_arg`; set `last_seq` to seq.
  - Status becomes {seq, opcode, 12'h0, 4'b0010} (busy only).
  - Next state is ISSUE.
- ISSUE: `cmd_valid` = 1, with `cmd_op`/`cmd_arg` held stable. A transfer occurs on `cmd_valid && cmd_ready`; next state is WAIT.
- WAIT: `cmd_valid` = 0. On `resp_done`: status[3:0] = {0, `resp_err`, 0, 1}; next state is IDLE.
- `resp_done` is ignored outside WAIT, including in the handshake cycle itself.
- A seq written while busy is neither queued nor dropped. It is accepted on the first IDLE cycle in which the accept condition holds, which gives an implicit one-deep pending slot.
- A rewrite of the same seq is ignored. Software must change seq to reissue a command.
- seq 0 never issues; software uses it to idle or clear.
- Status done/error/timeout bits persist until the next accept.

## Timing
- The accept condition true at edge N means:
  - status busy = 1 and `cmd_valid` = 1 after edge N.
  - ISSUE is the state for cycle N+1.
- The earliest `resp_done` that counts is one cycle after the handshake.
- `resp_done` sampled at edge M updates status after edge M. `busy` drops at that same edge.
- Back-to-back commands: the next accept can occur in the first IDLE cycle, i.e. 1 cycle after completion when a stable new seq is already present.
- With the timeout feature compiled in:
  - The counter clears on accept and increments every cycle in ISSUE or WAIT.
  - At count `TIMEOUT_CYCLES-1`: status[3:0] = 4'b1101, `cmd_valid` drops, state goes to IDLE.
  - If `resp_done` occurs in the same cycle, `resp_done` wins and timeout stays 0.
- `areset` asserted mid-command forces every output to 0 immediately (asynchronously). A command in flight is abandoned and never reported.
- Because `last_seq` resets to 0, a nonzero seq still present after reset re-issues 2 cycles after reset deasserts.

## Configuration
- `GPIO_CMD_TIMEOUT_EN` defined: the timeout counter and the abort path are built.
- Not defined:
  - The counter is removed; ISSUE and WAIT wait indefinitely.
  - status[3] is constant 0; `TIMEOUT_CYCLES` and `TO_WIDTH` are unused.

## Structure
- Package `gpio_cmd_pkg` holds:
  - State enum: IDLE, ISSUE, WAIT.
  - Field LSB/MSB constants for seq, opcode, arg.
  - Status bit indices: DONE=0, BUSY=1, ERR=2, TO=3.
- One sub-module, `gpio_cmd_timer`: a clear/enable/terminal-count counter, instantiated only under `GPIO_CMD_TIMEOUT_EN`.

## Test plan
- Reset, then `ctrl_word`=32'h01_05_1234 with `cmd_ready`=1:
  - `cmd_valid` high for exactly 1 cycle, with `cmd_op`=8'h05 and `cmd_arg`=16'h1234.
  - `resp_done` pulsed 3 cycles later gives `status_word`=32'h01_05_0001.
- `cmd_ready` held low 10 cycles with seq 02: `cmd_valid` and operands stay stable for all 10 cycles. Transfer happens on ready; `resp_err`=1 at done gives status=32'h02_xx_0005.
- `ctrl_word` changed to seq 04 during WAIT of seq 03: no second `cmd_valid` until done. Then seq 04 issues 1 cycle after IDLE, with status echo seq = 8'h04.
- Same seq rewritten, and seq 00 written: no `cmd_valid` in either case, and status unchanged.
- `GPIO_CMD_TIMEOUT_EN` with `TIMEOUT_CYCLES`=16 and `cmd_ready` stuck low: `cmd_valid` drops 16 cycles after accept; status[3:0]=4'b1101; `busy`=0.
- `areset` pulsed during WAIT: all outputs 0 immediately. After release, the still-present seq 07 re-issues 2 cycles later.
